pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-width stage registers between the MIPS pipeline stages.
- Carries one DATA_W-bit payload bundle (ALU result, store data, PC+4, write address and control fields, packed by the instantiating stage) with a valid/ready handshake.
- A two-entry skid buffer allows a downstream stall without a combinational ready path back up the pipe.
- A synchronous flush squashes wrong-path instructions.

---
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 tb/tb_pipe_stage_skid.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer, valid/ready handshake and flush.
// Define PIPE_STALL_CNT_EN to add a saturating stall_cnt output.
//
// state | meaning
// EMPTY | no payload held, in_ready = 1
// ONE   | main entry valid, skid empty, in_ready = 1
// FULL  | main and skid valid, in_ready = 0
module pipe_stage_skid #(
    parameter int          DATA_W         = 32,
    parameter logic [63:0] RST_VAL        = 64'd0,
    parameter int          FLUSH_CLR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [DATA_W-1:0] RST_D = DATA_W'(RST_VAL);

    // encoding is {skid_v, main_v}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;
    logic [1:0]        occ_q;
    logic              in_hs;
    logic              out_hs;

    assign out_valid = state[0];
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;
    assign in_hs     = in_valid && in_ready_q;
    assign out_hs    = state[0] && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            main_q     <= RST_D;
            skid_q     <= RST_D;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
        end else if (flush) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
            if (FLUSH_CLR_DATA != 0) begin
                main_q <= RST_D;
                skid_q <= RST_D;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_hs) begin
                        main_q <= in_data;
                        state  <= ONE;
                        occ_q  <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        main_q <= in_data;
                    end else if (out_hs) begin
                        state <= EMPTY;
                        occ_q <= 2'd0;
                    end else if (in_hs) begin
                        skid_q     <= in_data;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                        occ_q      <= 2'd2;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        main_q     <= skid_q;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                        occ_q      <= 2'd1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                    occ_q      <= 2'd0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'd0;
        end else if (state[0] && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised and directed scoreboard bench for pipe_stage_skid (DATA_W = 8, RST_VAL = 9'h1FF).
// The reference model treats the stage as a two-entry FIFO whose ready reflects the count at cycle start.
module tb_pipe_stage_skid;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pipe_stage_skid #(
        .DATA_W(8),
        .RST_VAL(64'h1FF),
        .FLUSH_CLR_DATA(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         held = 0;
    int         exp_stall = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic apply(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        if (v && !fl && held < 2) exp_q.push_back(d);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        apply(v, d, ordy, fl);
    endtask

    // monitor: compares DUT state against the model, then advances the model across the coming edge
    always @(negedge clk) begin
        if (mon_en) begin
            int pop;
            int acc;
            chk("out_valid", out_valid, held > 0);
            chk("in_ready", in_ready, held < 2);
            chk("occupancy", occupancy, held);
`ifdef PIPE_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, exp_stall);
            if (held > 0 && !out_ready) exp_stall++;
`endif
            if (flush) begin
                exp_q.delete();
                held = 0;
            end else begin
                pop = (held > 0 && out_ready) ? 1 : 0;
                acc = (in_valid && held < 2) ? 1 : 0;
                if (pop == 1) begin
                    chk("out_data", out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                held = held - pop + acc;
            end
        end
    end

    initial begin
        // reset and stream
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 8'hFF);
        #2;
        rst = 1'b1;
        mon_en = 1'b1;
        drive(1, 8'h11, 1, 0);
        drive(1, 8'h22, 1, 0);
        drive(1, 8'h33, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);

        // backpressure with A3 held upstream until accepted
        drive(1, 8'hA1, 0, 0);
        drive(1, 8'hA2, 0, 0);
        drive(1, 8'hA3, 0, 0);
        drive(1, 8'hA3, 1, 0);
        drive(1, 8'hA3, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);

        // flush while FULL, B3 offered in the flush cycle
        drive(1, 8'hB1, 0, 0);
        drive(1, 8'hB2, 0, 0);
        drive(1, 8'hB3, 0, 1);
        drive(0, 8'h00, 1, 0);
        chk("flush_out_data", out_data, 8'hFF);
        chk("flush_out_valid", out_valid, 0);
        drive(0, 8'h00, 1, 0);

        // async reset between edges while FULL
        drive(1, 8'hC1, 0, 0);
        drive(1, 8'hC2, 0, 0);
        drive(0, 8'h00, 0, 0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_occupancy", occupancy, 0);
        chk("arst_out_data", out_data, 8'hFF);
`ifdef PIPE_STALL_CNT_EN
        chk("arst_stall_cnt", stall_cnt, 0);
`endif
        exp_q.delete();
        held = 0;
        exp_stall = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        mon_en = 1'b1;

        // five stalled cycles, then a flush that must not disturb the stall count
        drive(1, 8'hD1, 0, 0);
        repeat (5) drive(0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
`ifdef PIPE_STALL_CNT_EN
        chk("stall_5", stall_cnt, 5);
`endif
        apply(0, 8'h00, 1, 1);
        drive(0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
`ifdef PIPE_STALL_CNT_EN
        chk("stall_after_flush", stall_cnt, 5);
`endif
        chk("flush2_out_valid", out_valid, 0);
        apply(0, 8'h00, 1, 0);

        // random stream against the FIFO model
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
        end
        repeat (4) drive(0, 8'h00, 1, 0);
        @(posedge clk);
        #1;
        chk("drain_occupancy", occupancy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
